// File: rtl/detect_faces_pkg.sv
// Shared widths and the round/saturate helper for the face-detection multiplier pipe.
// The helper works at a fixed 64-bit internal width so every instance can share it.
package detect_faces_pkg;

    localparam int DF_A_W      = 16;
    localparam int DF_B_W      = 10;
    localparam int DF_OUT_W    = 26;
    localparam int DF_SHIFT    = 0;
    localparam int DF_NUM_STAGE = 2;
    localparam int DF_CNT_W    = 16;
    localparam int DF_CALC_W   = 64;

    typedef struct packed {
        logic                        sat;
        logic signed [DF_CALC_W-1:0] val;
    } rs_t;

    // Round half toward +inf, then clip to a signed out_w-bit range.
    function automatic rs_t round_sat(input logic signed [DF_CALC_W-1:0] p,
                                      input int shift,
                                      input int out_w);
        logic signed [DF_CALC_W-1:0] half;
        logic signed [DF_CALC_W-1:0] r;
        logic signed [DF_CALC_W-1:0] max_v;
        logic signed [DF_CALC_W-1:0] min_v;
        rs_t res;
        half = '0;
        r    = p;
        if (shift > 0) begin
            half = 64'sd1 <<< (shift - 1);
            r    = (p + half) >>> shift;
        end
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        res.sat = 1'b0;
        res.val = r;
        if (r > max_v) begin
            res.sat = 1'b1;
            res.val = max_v;
        end else if (r < min_v) begin
            res.sat = 1'b1;
            res.val = min_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/detect_faces_pipe_ctl.sv
// Valid chain and load enables for the multiplier pipe.
// A single stall freezes every stage, empty or not.
module detect_faces_pipe_ctl #(
    parameter int NUM_STAGE = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    input  logic                 i_out_ready,
    output logic                 o_in_ready,
    output logic                 o_out_valid,
    output logic [NUM_STAGE-1:0] o_ld
);

    logic [NUM_STAGE-1:0] r_vld;
    logic [NUM_STAGE-1:0] w_vin;
    logic                 w_stall;

    always_comb begin
        w_vin    = '0;
        w_vin[0] = i_in_valid;
        for (int k = 1; k < NUM_STAGE; k++) begin
            w_vin[k] = r_vld[k-1];
        end
    end

    assign w_stall     = r_vld[NUM_STAGE-1] & ~i_out_ready;
    assign o_in_ready  = ~w_stall;
    assign o_out_valid = r_vld[NUM_STAGE-1];
    // Data registers only load when valid data is entering them.
    assign o_ld        = w_vin & {NUM_STAGE{~w_stall}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
        end else if (!w_stall) begin
            r_vld <= w_vin;
        end
    end

endmodule

// File: rtl/detect_faces_mul_pipe.sv
// Pipelined unsigned x signed multiplier with rounding shift, saturation and a
// saturation event counter, used for Haar-feature weighting.
module detect_faces_mul_pipe
    import detect_faces_pkg::*;
#(
    parameter int A_W       = DF_A_W,
    parameter int B_W       = DF_B_W,
    parameter int OUT_W     = DF_OUT_W,
    parameter int SHIFT     = DF_SHIFT,
    parameter int NUM_STAGE = DF_NUM_STAGE,
    parameter int CNT_W     = DF_CNT_W
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [A_W-1:0]          din0,
    input  logic signed [B_W-1:0]   din1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat,
    input  logic                    sat_clr,
    output logic [CNT_W-1:0]        sat_cnt
);

    localparam int P_W = A_W + B_W + 1;

    if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_chk_stage
        $error("detect_faces_mul_pipe: NUM_STAGE must be in 1..4");
    end
    if (OUT_W < 2 || OUT_W > A_W + B_W) begin : g_chk_out_w
        $error("detect_faces_mul_pipe: OUT_W must be in 2..A_W+B_W");
    end
    if (SHIFT < 0 || SHIFT > A_W + B_W - 1) begin : g_chk_shift
        $error("detect_faces_mul_pipe: SHIFT must be in 0..A_W+B_W-1");
    end

    logic [NUM_STAGE-1:0]        w_ld;
    logic [A_W-1:0]              r_a;
    logic signed [B_W-1:0]       r_b;
    logic signed [P_W-1:0]       w_prod;
    logic signed [P_W-1:0]       w_p_last;
    logic signed [DF_CALC_W-1:0] w_p_ext;
    rs_t                         w_rs;
    logic                        w_unused_hi;
    logic [CNT_W-1:0]            r_sat_cnt;

    detect_faces_pipe_ctl #(
        .NUM_STAGE (NUM_STAGE)
    ) u_ctl (
        .i_clk       (ap_clk),
        .i_rst_n     (ap_rst_n),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_ld        (w_ld)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_ld[0]) begin
            r_a <= din0;
            r_b <= din1;
        end
    end

    assign w_prod = P_W'($signed({1'b0, r_a})) * P_W'(r_b);

    // Stages 2..NUM_STAGE-1 only carry the raw product forward.
    if (NUM_STAGE > 2) begin : g_pdly
        logic signed [P_W-1:0] r_pd [NUM_STAGE-2];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                for (int i = 0; i < NUM_STAGE - 2; i++) begin
                    r_pd[i] <= '0;
                end
            end else begin
                if (w_ld[1]) r_pd[0] <= w_prod;
                for (int i = 1; i < NUM_STAGE - 2; i++) begin
                    if (w_ld[i+1]) r_pd[i] <= r_pd[i-1];
                end
            end
        end
        assign w_p_last = r_pd[NUM_STAGE-3];
    end else begin : g_pnodly
        assign w_p_last = w_prod;
    end

    assign w_p_ext     = DF_CALC_W'(w_p_last);
    assign w_rs        = round_sat(w_p_ext, SHIFT, OUT_W);
    assign w_unused_hi = ^w_rs.val[DF_CALC_W-1:OUT_W];

    if (NUM_STAGE == 1) begin : g_comb_out
        assign dout = w_rs.val[OUT_W-1:0];
        assign sat  = w_rs.sat;
    end else begin : g_reg_out
        logic [OUT_W-1:0] r_dout;
        logic             r_sat;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                r_dout <= '0;
                r_sat  <= 1'b0;
            end else if (w_ld[NUM_STAGE-1]) begin
                r_dout <= w_rs.val[OUT_W-1:0];
                r_sat  <= w_rs.sat;
            end
        end
        assign dout = r_dout;
        assign sat  = r_sat;
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (out_valid && out_ready && sat && !(&r_sat_cnt)) begin
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end

    assign sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_detect_faces_mul_pipe.sv
// Directed bench for detect_faces_mul_pipe: four configurations share one stimulus bus.
// d: defaults (2 stages), q: OUT_W16/SHIFT4/3 stages, h: SHIFT1/1 stage, c: OUT_W16/SHIFT4/4 stages/CNT_W2.
module tb_detect_faces_mul_pipe;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sat_clr = 1'b0;
    logic [15:0] din0 = '0;
    logic signed [9:0] din1 = '0;

    logic               d_in_ready, d_out_valid, d_sat;
    logic signed [25:0] d_dout;
    logic [15:0]        d_cnt;
    logic               q_in_ready, q_out_valid, q_sat;
    logic signed [15:0] q_dout;
    logic [15:0]        q_cnt;
    logic               h_in_ready, h_out_valid, h_sat;
    logic signed [25:0] h_dout;
    logic [15:0]        h_cnt;
    logic               c_in_ready, c_out_valid, c_sat;
    logic signed [15:0] c_dout;
    logic [1:0]         c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ap_clk = ~ap_clk;

    detect_faces_mul_pipe u_d (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
        .din0(din0), .din1(din1), .out_valid(d_out_valid), .out_ready(out_ready),
        .dout(d_dout), .sat(d_sat), .sat_clr(sat_clr), .sat_cnt(d_cnt)
    );

    detect_faces_mul_pipe #(.OUT_W(16), .SHIFT(4), .NUM_STAGE(3)) u_q (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(q_in_ready),
        .din0(din0), .din1(din1), .out_valid(q_out_valid), .out_ready(out_ready),
        .dout(q_dout), .sat(q_sat), .sat_clr(sat_clr), .sat_cnt(q_cnt)
    );

    detect_faces_mul_pipe #(.SHIFT(1), .NUM_STAGE(1)) u_h (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
        .din0(din0), .din1(din1), .out_valid(h_out_valid), .out_ready(out_ready),
        .dout(h_dout), .sat(h_sat), .sat_clr(sat_clr), .sat_cnt(h_cnt)
    );

    detect_faces_mul_pipe #(.OUT_W(16), .SHIFT(4), .NUM_STAGE(4), .CNT_W(2)) u_c (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .din0(din0), .din1(din1), .out_valid(c_out_valid), .out_ready(out_ready),
        .dout(c_dout), .sat(c_sat), .sat_clr(sat_clr), .sat_cnt(c_cnt)
    );

    typedef struct {
        int a;
        int b;
        int e_d;
        int e_h;
        int e_q;
        int s_q;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int s_a [8];
    int s_b [8];
    int s_exp [8];
    logic signed [25:0] held;
    logic was_stall;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{65535, -512, -33553920, -16776960, -32768, 1};
        vecs[1]  = '{1000,   100,    100000,     50000,   6250, 0};
        vecs[2]  = '{65535,  511,  33488385,  16744193,  32767, 1};
        vecs[3]  = '{3,       -1,        -3,        -1,      0, 0};
        vecs[4]  = '{3,        1,         3,         2,      0, 0};
        vecs[5]  = '{0,     -512,         0,         0,      0, 0};
        vecs[6]  = '{8,       -1,        -8,        -4,      0, 0};
        vecs[7]  = '{24,      -1,       -24,       -12,     -1, 0};
        vecs[8]  = '{2416,   217,    524272,    262136,  32767, 0};
        vecs[9]  = '{2056,   255,    524280,    262140,  32767, 1};
        vecs[10] = '{1024,  -512,   -524288,   -262144, -32768, 0};
        vecs[11] = '{1225,  -428,   -524300,   -262150, -32768, 1};
        vecs[12] = '{40000,  300,  12000000,   6000000,  32767, 1};

        // reset state
        #12;
        chk("rst_d_vld", d_out_valid, 0);
        chk("rst_d_dout", d_dout, 0);
        chk("rst_q_dout", q_dout, 0);
        chk("rst_c_vld", c_out_valid, 0);
        do_reset();
        chk("rst_d_rdy", d_in_ready, 1);
        chk("rst_q_rdy", q_in_ready, 1);
        chk("rst_h_rdy", h_in_ready, 1);
        chk("rst_c_rdy", c_in_ready, 1);
        chk("rst_d_sat", d_sat, 0);
        chk("rst_h_dout", h_dout, 0);
        chk("rst_d_cnt", d_cnt, 0);
        chk("rst_q_cnt", q_cnt, 0);
        chk("rst_h_cnt", h_cnt, 0);
        chk("rst_c_cnt", c_cnt, 0);

        // single transactions: value and exact latency per configuration
        for (int v = 0; v < NV; v++) begin
            @(negedge ap_clk);
            in_valid = 1'b1;
            din0 = 16'(vecs[v].a);
            din1 = 10'(vecs[v].b);
            #1;
            chk("vec_in_ready", d_in_ready, 1);
            for (int c = 1; c <= 5; c++) begin
                @(negedge ap_clk);
                in_valid = 1'b0;
                #1;
                chk("h_vld", h_out_valid, c == 1);
                chk("d_vld", d_out_valid, c == 2);
                chk("q_vld", q_out_valid, c == 3);
                chk("c_vld", c_out_valid, c == 4);
                if (c == 1) begin
                    chk("h_dout", h_dout, vecs[v].e_h);
                    chk("h_sat", h_sat, 0);
                end
                if (c == 2) begin
                    chk("d_dout", d_dout, vecs[v].e_d);
                    chk("d_sat", d_sat, 0);
                end
                if (c == 3) begin
                    chk("q_dout", q_dout, vecs[v].e_q);
                    chk("q_sat", q_sat, vecs[v].s_q);
                end
                if (c == 4) begin
                    chk("c_dout", c_dout, vecs[v].e_q);
                    chk("c_sat", c_sat, vecs[v].s_q);
                end
            end
        end
        chk("tbl_q_cnt", q_cnt, 5);
        chk("tbl_c_cnt_stick", c_cnt, 3);
        chk("tbl_d_cnt", d_cnt, 0);
        chk("tbl_h_cnt", h_cnt, 0);

        // streaming with backpressure on cycles 3..5
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s_a[i]   = 1000 * (i + 1);
            s_b[i]   = (i % 2 == 1) ? -(7 * i + 3) : (5 * i + 1);
            s_exp[i] = s_a[i] * s_b[i];
        end
        begin
            int ii;
            int oi;
            ii = 0;
            oi = 0;
            was_stall = 1'b0;
            held = '0;
            for (int t = 0; t < 40; t++) begin
                @(negedge ap_clk);
                out_ready = !(t >= 3 && t <= 5);
                in_valid  = (ii < 8);
                din0 = 16'(s_a[(ii < 8) ? ii : 0]);
                din1 = 10'(s_b[(ii < 8) ? ii : 0]);
                #1;
                if (t <= 8) chk("strm_in_ready", d_in_ready, !(t >= 3 && t <= 5));
                if (was_stall) chk("strm_hold", d_dout, held);
                if (d_out_valid && out_ready) begin
                    if (oi < 8) chk("strm_dout", d_dout, s_exp[oi]);
                    else chk("strm_extra_out", oi, 7);
                    oi++;
                end
                was_stall = d_out_valid && !out_ready;
                held = d_dout;
                if (d_in_ready && in_valid) ii++;
            end
            chk("strm_in_count", ii, 8);
            chk("strm_out_count", oi, 8);
        end

        // saturation counter: three hits, then clear coinciding with a fourth
        do_reset();
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0 = 16'd65535;
        din1 = 10'sd511;
        repeat (3) @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (6) @(negedge ap_clk);
        #1;
        chk("cnt_three", q_cnt, 3);
        @(negedge ap_clk);
        in_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge ap_clk);
            in_valid = 1'b0;
            sat_clr = (c == 3);
            #1;
            if (c == 3) begin
                chk("clr_q_vld", q_out_valid, 1);
                chk("clr_q_sat", q_sat, 1);
                chk("clr_pre_cnt", q_cnt, 3);
            end
            if (c == 4) chk("clr_priority", q_cnt, 0);
        end

        // asynchronous reset with two values in flight
        do_reset();
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0 = 16'd65535;
        din1 = 10'sd511;
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (5) @(negedge ap_clk);
        #1;
        chk("arst_pre_cnt", q_cnt, 1);
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0 = 16'd1000;
        din1 = 10'sd100;
        @(negedge ap_clk);
        din0 = 16'd3;
        din1 = 10'sd1;
        @(negedge ap_clk);
        in_valid = 1'b0;
        #1;
        chk("arst_pre_vld", d_out_valid, 1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_d_vld", d_out_valid, 0);
        chk("arst_h_vld", h_out_valid, 0);
        chk("arst_d_dout", d_dout, 0);
        chk("arst_q_cnt", q_cnt, 0);
        chk("arst_c_cnt", c_cnt, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge ap_clk);
            #1;
            chk("post_d_vld", d_out_valid, 0);
            chk("post_q_vld", q_out_valid, 0);
            chk("post_h_vld", h_out_valid, 0);
            chk("post_c_vld", c_out_valid, 0);
        end
        chk("post_q_cnt", q_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
